arbiter_puf_ctrl: RTL and testbench

Parametrised, self-timed arbiter-PUF evaluator: instantiates `N_CH` arbiter delay chains sharing one `C_W`-bit challenge and sequences precharge, launch, settle and capture itself instead of relying on an externally toggled start line. Responses pass through a two-flop synchroniser and are returned over a valid/ready handshake. Optional majority voting over repeated evaluations yields stable response bits plus per-bit instability flags. Sits between the challenge/response host logic (UART/AXI bridge) and the raw arbiter chains.

---
 rtl/arbiter_puf_ctrl.sv | 178 +++++++++++++++++
 tb/tb_arbiter_puf_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_puf_ctrl.sv
// arbiter_puf_ctrl: self-timed controller for N_CH arbiter PUF chains.
// It sequences precharge, launch, settle and sample for each evaluation,
// then returns the response bits over a valid/ready handshake.
// Compile-time option: define ARBITER_PUF_VOTE_EN to run VOTES evaluations
// per request, majority-vote each bit and report per-bit instability.
// Without the macro, each request runs a single evaluation and
// resp_unstable is always 0.

// Behavioural stand-in for one arbiter delay chain. The real chain is a
// hand-placed mux ladder with a latch, and it replaces this model in the
// implementation flow.
module arbiter #(
   parameter int C_W = 64
) (
   input  logic [C_W-1:0] chal_i,
   input  logic           top_i,
   input  logic           bot_i,
   output logic           resp_o
);
   assign resp_o = top_i & bot_i & (^chal_i);
endmodule

module arbiter_puf_ctrl #(
   parameter int N_CH       = 8,
   parameter int C_W        = 64,
   parameter int PRE_CYC    = 4,
   parameter int SETTLE_CYC = 16,
   parameter int VOTES      = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [C_W-1:0]  req_chal,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [N_CH-1:0] resp_data,
   output logic [N_CH-1:0] resp_unstable
);

`ifdef ARBITER_PUF_VOTE_EN
   localparam int V = VOTES;
`else
   // Single-shot build: the vote count is fixed at one evaluation.
   localparam int V = 1 + 0 * VOTES;
`endif
   localparam int OW      = $clog2(V + 1);
   localparam int CNT_MAX = (PRE_CYC > SETTLE_CYC) ? PRE_CYC : SETTLE_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {IDLE, PRE, RUN, SAMPLE, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [OW-1:0]   vote_idx_q, vote_idx_d;
   logic [OW-1:0]   ones_q [N_CH];
   logic [OW-1:0]   ones_d [N_CH];
   logic [C_W-1:0]  chal_q, chal_d;
   logic            launch_q, launch_d;
   logic            req_ready_q, resp_valid_q;
   logic [N_CH-1:0] data_q, data_d, unst_q, unst_d;
   logic [N_CH-1:0] arb_out, sync1_q, sync2_q;

   // One arbiter per response bit; both race inputs share the launch line.
   for (genvar gi = 0; gi < N_CH; gi++) begin : g_chain
      arbiter #(.C_W(C_W)) u_arb (
         .chal_i (chal_q),
         .top_i  (launch_q),
         .bot_i  (launch_q),
         .resp_o (arb_out[gi])
      );
   end

   // Two-flop synchroniser on the asynchronous arbiter outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= arb_out;
         sync2_q <= sync1_q;
      end
   end

   // Next-state logic: evaluation sequencing, vote accumulation, result.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      vote_idx_d = vote_idx_q;
      chal_d     = chal_q;
      data_d     = data_q;
      unst_d     = unst_q;
      for (int i = 0; i < N_CH; i++) ones_d[i] = ones_q[i];
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               chal_d     = req_chal;
               vote_idx_d = '0;
               cnt_d      = '0;
               for (int i = 0; i < N_CH; i++) ones_d[i] = '0;
               state_d    = PRE;
            end
         end
         PRE: begin
            if (cnt_q == CW'(PRE_CYC - 1)) begin
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RUN: begin
            if (cnt_q == CW'(SETTLE_CYC - 1)) begin
               cnt_d   = '0;
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         SAMPLE: begin
            for (int i = 0; i < N_CH; i++) ones_d[i] = ones_q[i] + OW'(sync2_q[i]);
            vote_idx_d = vote_idx_q + OW'(1);
            if (int'(vote_idx_q) + 1 < V) begin
               state_d = PRE;
            end else begin
               state_d = DONE;
               for (int i = 0; i < N_CH; i++) begin
                  data_d[i] = (int'(ones_d[i]) > V / 2);
`ifdef ARBITER_PUF_VOTE_EN
                  unst_d[i] = (ones_d[i] != '0) && (int'(ones_d[i]) < V);
`else
                  unst_d[i] = 1'b0;
`endif
               end
            end
         end
         DONE: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Launch is high for the whole settle window and the sample cycle.
      launch_d = (state_d == RUN) || (state_d == SAMPLE);
   end

   // State and datapath registers; reset drops any request in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         vote_idx_q   <= '0;
         chal_q       <= '0;
         launch_q     <= 1'b0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         data_q       <= '0;
         unst_q       <= '0;
         for (int i = 0; i < N_CH; i++) ones_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         vote_idx_q   <= vote_idx_d;
         chal_q       <= chal_d;
         launch_q     <= launch_d;
         req_ready_q  <= (state_d == IDLE);
         resp_valid_q <= (state_d == DONE);
         data_q       <= data_d;
         unst_q       <= unst_d;
         for (int i = 0; i < N_CH; i++) ones_q[i] <= ones_d[i];
      end
   end

   assign req_ready     = req_ready_q;
   assign resp_valid    = resp_valid_q;
   assign resp_data     = data_q;
   assign resp_unstable = unst_q;

endmodule

// File: tb/tb_arbiter_puf_ctrl.sv
// Testbench for arbiter_puf_ctrl: the chain outputs are forced from the
// bench, expected responses go into a scoreboard queue, and a monitor
// compares them whenever resp_valid rises.
module tb_arbiter_puf_ctrl;
   localparam int N_CH = 8;
   localparam int C_W  = 64;
   localparam int PRE  = 4;
   localparam int SET  = 16;
   localparam int E    = PRE + SET + 1;
`ifdef ARBITER_PUF_VOTE_EN
   localparam int       V      = 5;
   localparam bit [7:0] VOTE_D = 8'h15;
   localparam bit [7:0] VOTE_U = 8'h13;
`else
   localparam int       V      = 1;
   localparam bit [7:0] VOTE_D = 8'h07;
   localparam bit [7:0] VOTE_U = 8'h00;
`endif

   logic            clk = 1'b0;
   logic            rst, req_valid, resp_ready;
   logic            req_ready, resp_valid;
   logic [C_W-1:0]  req_chal;
   logic [N_CH-1:0] resp_data, resp_unstable;
   logic [N_CH-1:0] force_v;

   arbiter_puf_ctrl #(
      .N_CH(N_CH), .C_W(C_W), .PRE_CYC(PRE), .SETTLE_CYC(SET), .VOTES(5)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_chal(req_chal), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_unstable(resp_unstable)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] d;
      logic [7:0] u;
      int         acc;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task set_ch(input logic [7:0] v);
      force_v = v;
      force dut.arb_out = force_v;
   endtask

   // Scoreboard monitor: pops on every rising resp_valid, then checks hold.
   initial begin : monitor
      logic       prev_v;
      logic [7:0] held_d;
      exp_t       e;
      prev_v = 1'b0;
      held_d = '0;
      forever begin
         @(negedge clk);
         if (resp_valid && !prev_v) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp: got data %0h with no request outstanding", resp_data);
            end else begin
               e = sb.pop_front();
               chk("resp_data", resp_data, e.d);
               chk("resp_unstable", resp_unstable, e.u);
               chk("latency", 64'(cyc - e.acc), 64'(V * E));
               $display("resp data=%h unstable=%h latency=%0d", resp_data, resp_unstable, cyc - e.acc);
            end
            held_d = resp_data;
         end else if (resp_valid) begin
            chk("hold_data", resp_data, held_d);
         end
         prev_v = resp_valid;
      end
   end

   // Launch-line run-length monitor, enabled for one request.
   bit   lm_en = 1'b0;
   int   lm_len, lm_pulses;
   logic lm_prev;
   initial begin : launch_mon
      forever begin
         @(negedge clk);
         if (lm_en) begin
            if (dut.launch_q === lm_prev) begin
               lm_len++;
            end else begin
               if (lm_prev) chk("launch_high", 64'(lm_len), 64'(SET + 1));
               else if (lm_pulses > 0) chk("launch_low", 64'(lm_len), 64'(PRE));
               if (dut.launch_q) lm_pulses++;
               lm_len = 1;
            end
            lm_prev = dut.launch_q;
         end
      end
   end

   task automatic issue(input logic [63:0] chal, input logic [7:0] ed, input logic [7:0] eu);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_chal  = chal;
      while (!req_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: req_ready low for %0d cycles", n);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      e.d = ed; e.u = eu; e.acc = cyc;
      sb.push_back(e);
      $display("req chal=%h accepted at cycle %0d", chal, cyc);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!resp_valid && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!resp_valid) begin
         checks++;
         errors++;
         $display("FAIL resp_timeout: resp_valid low after %0d cycles", n);
      end
   endtask

   task automatic wait_launch_fall();
      int n;
      n = 0;
      while (dut.launch_q !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      while (dut.launch_q !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         checks++;
         errors++;
         $display("FAIL launch_timeout: no launch pulse within %0d cycles", n);
      end
   endtask

   logic [7:0] pats [5];
   int hs_cyc, acc_cyc;
   exp_t e2;

   initial begin
      pats[0] = 8'h07; pats[1] = 8'h16; pats[2] = 8'h15; pats[3] = 8'h14; pats[4] = 8'h15;
      rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1; req_chal = '0;
      set_ch(8'h00);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_resp_unstable", resp_unstable, 0);
      chk("rst_launch", dut.launch_q, 0);

      // Uniform response, launch timing observed.
      set_ch(8'hC3);
      lm_prev = 1'b0; lm_len = 0; lm_pulses = 0; lm_en = 1'b1;
      issue(64'hA5A5_A5A5_A5A5_A5A5, 8'hC3, 8'h00);
      wait_valid();
      repeat (3) @(negedge clk);
      lm_en = 1'b0;
      chk("launch_pulses", 64'(lm_pulses), 64'(V));

      // Per-evaluation patterns exercise majority and instability.
      set_ch(pats[0]);
      issue(64'h0123_4567_89AB_CDEF, VOTE_D, VOTE_U);
      for (int k = 1; k < V; k++) begin
         wait_launch_fall();
         set_ch(pats[k]);
      end
      wait_valid();
      repeat (2) @(negedge clk);

      // Backpressure: a second request waits until the first is consumed.
      resp_ready = 1'b0;
      set_ch(8'h5A);
      issue(64'hDEAD_BEEF_0000_0001, 8'h5A, 8'h00);
      wait_valid();
      req_valid = 1'b1;
      req_chal  = 64'h0000_0000_FFFF_0002;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_resp_valid", resp_valid, 1);
      end
      resp_ready = 1'b1;
      set_ch(8'h3C);
      @(posedge clk);
      #1;
      hs_cyc = cyc;
      @(negedge clk);
      chk("bp_ready_back", req_ready, 1);
      chk("bp_valid_drop", resp_valid, 0);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      req_valid = 1'b0;
      e2.d = 8'h3C; e2.u = 8'h00; e2.acc = acc_cyc;
      sb.push_back(e2);
      $display("req chal=%h accepted at cycle %0d", req_chal, acc_cyc);
      chk("bp_accept_next_cycle", 64'(acc_cyc - hs_cyc), 1);
      @(negedge clk);
      chk("bp_busy_after_accept", req_ready, 0);
      wait_valid();
      repeat (2) @(negedge clk);

      // Reset in the middle of an evaluation drops the request.
      set_ch(8'hFF);
      issue(64'h1111_2222_3333_4444, 8'hFF, 8'h00);
      for (int k = 0; k < ((V >= 3) ? 2 : 0); k++) wait_launch_fall();
      repeat (6) @(negedge clk);
      rst = 1'b1;
      void'(sb.pop_back());
      @(negedge clk);
      chk("mid_rst_req_ready", req_ready, 1);
      chk("mid_rst_launch", dut.launch_q, 0);
      chk("mid_rst_resp_valid", resp_valid, 0);
      chk("mid_rst_resp_data", resp_data, 0);
      chk("mid_rst_resp_unstable", resp_unstable, 0);
      rst = 1'b0;
      set_ch(8'h81);
      issue(64'h5555_6666_7777_8888, 8'h81, 8'h00);
      wait_valid();
      repeat (3) @(negedge clk);

      chk("scoreboard_empty", 64'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
